// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with reset vector, redirects, alignment check, halt/resume and fetch counter
module pc_gen #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter bit C_EXT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            br_redirect,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_redirect,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr,
  output logic [31:0]     fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  localparam logic [XLEN-1:0] AMASK = C_EXT ? XLEN'(1) : XLEN'(3);
  state_t state;
  logic accept, br_mis, br_ok, br_rej;
  logic [XLEN-1:0] pc_next;
  always_comb begin
    accept = state == RUN && fetch_ready && !stall;
    br_mis = |(br_target & AMASK);
    br_ok = br_redirect && !br_mis;
    br_rej = br_redirect && br_mis && !trap_redirect;
    pc_next = trap_redirect ? trap_target & ~AMASK : br_ok ? br_target : accept ? pc + XLEN'(4) : pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VEC;
      state <= BOOT;
      misalign_err <= 1'b0;
      misalign_addr <= '0;
      fetch_count <= '0;
    end else begin
      pc <= pc_next;
      fetch_count <= fetch_count + 32'(accept && !trap_redirect && !br_ok);
      misalign_err <= br_rej;
      if (br_rej) misalign_addr <= br_target;
      state <= state == BOOT ? RUN : state == RUN ? (halt_req ? HALTED : RUN) : (resume || trap_redirect ? RUN : HALTED);
    end
  end
  assign pc_valid = state == RUN;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen (64-bit C_EXT=0 main, plus C_EXT=1 and 32-bit variants)
module tb_pc_gen;
  logic clk = 0, rst = 1, stall = 0, fetch_ready = 0, br_redirect = 0, trap_redirect = 0, halt_req = 0, resume = 0;
  logic [63:0] br_target = '0, trap_target = '0;
  logic [63:0] pc0, pc1, ma0, ma1;
  logic [31:0] pc2, ma2, fc0, fc1, fc2;
  logic v0, v1, v2, e0, e1, e2;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic [63:0] pc; logic v; logic [31:0] cnt; logic err;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  pc_gen #(.XLEN(64), .RESET_VEC(64'h1000), .C_EXT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready), .br_redirect(br_redirect), .br_target(br_target),
    .trap_redirect(trap_redirect), .trap_target(trap_target), .halt_req(halt_req), .resume(resume),
    .pc(pc0), .pc_valid(v0), .misalign_err(e0), .misalign_addr(ma0), .fetch_count(fc0));
  pc_gen #(.XLEN(64), .RESET_VEC(64'h1000), .C_EXT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready), .br_redirect(br_redirect), .br_target(br_target),
    .trap_redirect(trap_redirect), .trap_target(trap_target), .halt_req(halt_req), .resume(resume),
    .pc(pc1), .pc_valid(v1), .misalign_err(e1), .misalign_addr(ma1), .fetch_count(fc1));
  pc_gen #(.XLEN(32), .RESET_VEC(32'h1000), .C_EXT(1'b0)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready), .br_redirect(br_redirect), .br_target(br_target[31:0]),
    .trap_redirect(trap_redirect), .trap_target(trap_target[31:0]), .halt_req(halt_req), .resume(resume),
    .pc(pc2), .pc_valid(v2), .misalign_err(e2), .misalign_addr(ma2), .fetch_count(fc2));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic [63:0] pc, input logic v, input logic [31:0] cnt, input logic err);
    exp_t e;
    q.push_back('{pc, v, cnt, err});
    @(posedge clk);
    #1;
    if (q.size() == 0) check({tag, " queue"}, 64'd0, 64'd1);
    else begin
      e = q.pop_front();
      check({tag, " pc"}, pc0, e.pc);
      check({tag, " valid"}, {63'd0, v0}, {63'd0, e.v});
      check({tag, " count"}, {32'd0, fc0}, {32'd0, e.cnt});
      check({tag, " err"}, {63'd0, e0}, {63'd0, e.err});
    end
  endtask
  initial begin
    fetch_ready = 1;
    step("reset", 64'h1000, 0, 0, 0);
    check("reset maddr", ma0, 64'h0);
    rst = 0;
    step("boot", 64'h1000, 1, 0, 0);
    step("seq1", 64'h1004, 1, 1, 0);
    step("seq2", 64'h1008, 1, 2, 0);
    stall = 1;
    for (int i = 0; i < 2; i++) step("stall", 64'h1008, 1, 2, 0);
    br_redirect = 1; br_target = 64'h2000;
    step("stall br", 64'h2000, 1, 2, 0);
    stall = 0; br_redirect = 0;
    step("seq3", 64'h2004, 1, 3, 0);
    trap_redirect = 1; trap_target = 64'h8000_0003; br_redirect = 1; br_target = 64'h3000;
    step("trap+br", 64'h8000_0000, 1, 3, 0);
    trap_redirect = 0; br_target = 64'h3002;
    step("misalign", 64'h8000_0004, 1, 4, 1);
    check("misalign addr", ma0, 64'h3002);
    check("cext taken", pc1, 64'h3002);
    check("cext no err", {63'd0, e1}, 64'd0);
    br_redirect = 0;
    step("err pulse end", 64'h8000_0008, 1, 5, 0);
    check("maddr stable", ma0, 64'h3002);
    br_redirect = 1; br_target = 64'h1010;
    step("br 1010", 64'h1010, 1, 5, 0);
    br_redirect = 0; halt_req = 1;
    step("halt accept", 64'h1014, 0, 6, 0);
    halt_req = 0; stall = 1;
    for (int i = 0; i < 5; i++) step("halted hold", 64'h1014, 0, 6, 0);
    stall = 0; halt_req = 1; resume = 1;
    step("resume wins", 64'h1014, 1, 6, 0);
    resume = 1;
    step("halt wins", 64'h1018, 0, 7, 0);
    halt_req = 0; resume = 0; trap_redirect = 1; trap_target = 64'h400;
    step("trap wake", 64'h400, 1, 7, 0);
    trap_redirect = 0; fetch_ready = 0;
    step("not ready", 64'h400, 1, 7, 0);
    fetch_ready = 1;
    step("ready", 64'h404, 1, 8, 0);
    br_redirect = 1; br_target = 64'h500;
    step("br no count", 64'h500, 1, 8, 0);
    br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step("br top", 64'hFFFF_FFFF_FFFF_FFFC, 1, 8, 0);
    check("x32 br top", {32'd0, pc2}, 64'hFFFF_FFFC);
    br_redirect = 0;
    step("wrap", 64'h0, 1, 9, 0);
    check("x32 wrap", {32'd0, pc2}, 64'h0);
    rst = 1; trap_redirect = 1; trap_target = 64'h700; br_redirect = 1; br_target = 64'h3; halt_req = 1;
    step("mid reset", 64'h1000, 0, 0, 0);
    check("mid reset maddr", ma0, 64'h0);
    check("x32 reset pc", {32'd0, pc2}, 64'h1000);
    rst = 0; trap_redirect = 0; br_redirect = 0; halt_req = 0;
    step("reboot", 64'h1000, 1, 0, 0);
    step("reboot seq", 64'h1004, 1, 1, 0);
    check("queue drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
